// File: rtl/layer0_pkg.sv
// Shared layer-0 types and defaults for the tile scheduler.
// FSM state encoding plus default layer geometry.
package layer0_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int IFM_SIZE    = 416;
  localparam int IFM_CHANNEL = 3;
  localparam int ADDR_WIDTH  = 18;
  localparam int NUM_FILTER  = 32;
  localparam int PE_COLS     = 16;
  localparam int OFM_SIZE    = IFM_SIZE;
  localparam int NUM_GRP     = NUM_FILTER / PE_COLS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_IFM,
    S_COMPUTE,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/layer0_tile_scheduler_cnt.sv
// Nested row/group counter for the tile scheduler.
// Row is the inner loop; it saturates at the last row/group.
module sched_loop_cnt #(
  parameter int ROW_W   = 9,
  parameter int GRP_W   = 4,
  parameter int ROW_MAX = 415,
  parameter int GRP_MAX = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [ROW_W-1:0] o_row,
  output logic [GRP_W-1:0] o_grp,
  output logic             o_row_last,
  output logic             o_grp_last
);
  import layer0_pkg::*;

  logic [ROW_W-1:0] r_row;
  logic [GRP_W-1:0] r_grp;
  logic             w_row_last;
  logic             w_grp_last;

  assign w_row_last = (r_row == ROW_W'(ROW_MAX));
  assign w_grp_last = (r_grp == GRP_W'(GRP_MAX));

  // Advance row; on row wrap advance group; hold at the very end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_grp <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_grp <= '0;
    end else if (i_inc) begin
      if (!w_row_last) begin
        r_row <= r_row + 1'b1;
      end else if (!w_grp_last) begin
        r_row <= '0;
        r_grp <= r_grp + 1'b1;
      end
    end
  end

  assign o_row      = r_row;
  assign o_grp      = r_grp;
  assign o_row_last = w_row_last;
  assign o_grp_last = w_grp_last;

endmodule

// File: rtl/layer0_tile_scheduler.sv
// Layer-0 tile scheduler: walks filter groups and output rows.
// Optional SCHED_PERF_CNT_EN adds the stall_cycles counter port.
module layer0_tile_scheduler #(
  parameter int KERNEL_SIZE = layer0_pkg::KERNEL_SIZE,
  parameter int IFM_SIZE    = layer0_pkg::IFM_SIZE,
  parameter int IFM_CHANNEL = layer0_pkg::IFM_CHANNEL,
  parameter int NUM_FILTER  = layer0_pkg::NUM_FILTER,
  parameter int PE_COLS     = layer0_pkg::PE_COLS,
  parameter int ROW_W       = 9,
  parameter int GRP_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wgt_done,
  input  logic             ifm_done,
  input  logic             array_done,
  input  logic             ofm_done,
  output logic             wgt_load,
  output logic             ifm_load,
  output logic             compute_en,
  output logic [ROW_W-1:0] row_idx,
  output logic [GRP_W-1:0] grp_idx,
  output logic             busy,
`ifdef SCHED_PERF_CNT_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic             layer_done
);
  import layer0_pkg::*;

  localparam int GRP_N = NUM_FILTER / PE_COLS;

  if ((IFM_SIZE - 1) >= (1 << ROW_W)) begin : g_bad_row_w
    $error("ROW_W too narrow for IFM_SIZE-1");
  end
  if ((GRP_N - 1) >= (1 << GRP_W)) begin : g_bad_grp_w
    $error("GRP_W too narrow for group count");
  end
  if ((NUM_FILTER % PE_COLS) != 0 || NUM_FILTER < PE_COLS) begin : g_bad_grp
    $error("NUM_FILTER must be a multiple of PE_COLS");
  end
  if ((KERNEL_SIZE % 2) == 0 || KERNEL_SIZE > IFM_SIZE
      || IFM_CHANNEL < 1) begin : g_bad_geom
    $error("invalid kernel/channel geometry");
  end

  sched_state_t r_state;
  sched_state_t w_state_n;
  logic         w_inc;
  logic         w_clr;
  logic         w_row_last;
  logic         w_grp_last;
  logic         r_wgt_load;
  logic         r_ifm_load;
  logic         r_compute_en;
  logic         r_busy;
  logic         r_layer_done;

  sched_loop_cnt #(
    .ROW_W   (ROW_W),
    .GRP_W   (GRP_W),
    .ROW_MAX (IFM_SIZE - 1),
    .GRP_MAX (GRP_N - 1)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_inc      (w_inc),
    .o_row      (row_idx),
    .o_grp      (grp_idx),
    .o_row_last (w_row_last),
    .o_grp_last (w_grp_last)
  );

  // Next-state and counter control
  always_comb begin
    w_state_n = r_state;
    w_inc     = 1'b0;
    w_clr     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr     = 1'b1;
          w_state_n = S_LOAD_W;
        end
      end
      S_LOAD_W:   if (wgt_done)   w_state_n = S_LOAD_IFM;
      S_LOAD_IFM: if (ifm_done)   w_state_n = S_COMPUTE;
      S_COMPUTE:  if (array_done) w_state_n = S_DRAIN;
      S_DRAIN:    if (ofm_done)   w_state_n = S_NEXT;
      S_NEXT: begin
        w_inc = 1'b1;
        if (!w_row_last)      w_state_n = S_LOAD_IFM;
        else if (!w_grp_last) w_state_n = S_LOAD_W;
        else                  w_state_n = S_DONE;
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register and registered outputs decoded from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wgt_load   <= 1'b0;
      r_ifm_load   <= 1'b0;
      r_compute_en <= 1'b0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_wgt_load   <= (w_state_n == S_LOAD_W)
                      && (r_state != S_LOAD_W);
      r_ifm_load   <= (w_state_n == S_LOAD_IFM)
                      && (r_state != S_LOAD_IFM);
      r_compute_en <= (w_state_n == S_COMPUTE);
      r_busy       <= (w_state_n != S_IDLE);
      r_layer_done <= (w_state_n == S_DONE);
    end
  end

  assign wgt_load   = r_wgt_load;
  assign ifm_load   = r_ifm_load;
  assign compute_en = r_compute_en;
  assign busy       = r_busy;
  assign layer_done = r_layer_done;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall;

  // Count cycles spent waiting on loads or write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stall <= '0;
    end else if (r_state == S_LOAD_W || r_state == S_LOAD_IFM
                 || r_state == S_DRAIN) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_layer0_tile_scheduler.sv
// Scoreboard bench for layer0_tile_scheduler (IFM_SIZE=4, 2 groups).
// Define SCHED_PERF_CNT_EN to also check stall_cycles.
module tb_layer0_tile_scheduler;

  localparam int R = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_start = 1'b0;
  logic       inj_start = 1'b0;
  logic       start;
  logic       rsp_w = 1'b0;
  logic       rsp_i = 1'b0;
  logic       inj_i = 1'b0;
  logic       rsp_a = 1'b0;
  logic       rsp_o = 1'b0;
  logic       ifm_done;
  logic       wgt_load;
  logic       ifm_load;
  logic       compute_en;
  logic       busy;
  logic       layer_done;
  logic [8:0] row_idx;
  logic [3:0] grp_idx;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  assign start    = tb_start | inj_start;
  assign ifm_done = rsp_i | inj_i;

  layer0_tile_scheduler #(
    .KERNEL_SIZE (3),
    .IFM_SIZE    (R),
    .IFM_CHANNEL (3),
    .NUM_FILTER  (32),
    .PE_COLS     (16),
    .ROW_W       (9),
    .GRP_W       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .wgt_done     (rsp_w),
    .ifm_done     (ifm_done),
    .array_done   (rsp_a),
    .ofm_done     (rsp_o),
    .wgt_load     (wgt_load),
    .ifm_load     (ifm_load),
    .compute_en   (compute_en),
    .row_idx      (row_idx),
    .grp_idx      (grp_idx),
    .busy         (busy),
`ifdef SCHED_PERF_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .layer_done   (layer_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int kind;
    int row;
    int grp;
  } ev_t;

  ev_t sb[$];

  int dw = 1, di = 1, da = 1, dofm = 1;
  bit inject = 1'b0;
  int exp_len = 0, exp_ce = 0, exp_stall = 0;
  int n_done = 0;

  task automatic push_layer();
    for (int g = 0; g < G; g++) begin
      sb.push_back('{0, 0, g});
      for (int r = 0; r < R; r++) sb.push_back('{1, r, g});
    end
    sb.push_back('{2, R - 1, G - 1});
    exp_len   = G * ((dw + 1) + R * ((di + 1) + da + dofm + 1)) + 1;
    exp_ce    = G * R * da;
    exp_stall = G * ((dw + 1) + R * ((di + 1) + dofm));
  endtask

  // Done responders: each reply follows its trigger by a set latency
  initial begin
    int cw = -1, ci = -1, ca = -1, co = -1;
    bit pa = 1'b0;
    forever begin
      @(negedge clk);
      rsp_w = 0; rsp_i = 0; rsp_a = 0; rsp_o = 0; inj_i = 0;
      if (!rst_n) begin
        cw = -1; ci = -1; ca = -1; co = -1; pa = 0;
        inj_start = 0;
      end else begin
        if (cw > 0) begin cw--; if (cw == 0) begin rsp_w = 1; cw = -1; end end
        if (ci > 0) begin ci--; if (ci == 0) begin rsp_i = 1; ci = -1; end end
        if (ca > 0) begin ca--; if (ca == 0) begin rsp_a = 1; ca = -1; end end
        if (co > 0) begin co--; if (co == 0) begin rsp_o = 1; co = -1; end end
        if (wgt_load) cw = dw;
        if (ifm_load) ci = di;
        if (rsp_i) ca = da;
        if (rsp_a) co = dofm;
        inj_start = inject && (compute_en || layer_done);
        inj_i = inject && pa;
        pa = rsp_a;
      end
    end
  end

  task automatic pop(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected pulse kind", k, -1);
    end else begin
      e = sb.pop_front();
      chk("pulse kind", k, e.kind);
      chk("pulse row", row_idx, e.row);
      chk("pulse grp", grp_idx, e.grp);
    end
  endtask

  // Monitor: pops the scoreboard on every DUT pulse
  initial begin
    int bc = 0, cc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0; cc = 0;
      end else begin
        if (busy) bc++;
        if (compute_en) cc++;
        if (wgt_load) pop(0);
        if (ifm_load) pop(1);
        if (layer_done) begin
          pop(2);
          chk("layer length", bc, exp_len);
          chk("compute cycles", cc, exp_ce);
`ifdef SCHED_PERF_CNT_EN
          chk("stall_cycles", stall_cycles, exp_stall);
`endif
          bc = 0; cc = 0;
          n_done++;
        end
      end
    end
  end

  function automatic logic [18:0] outs();
    return {wgt_load, ifm_load, compute_en, busy, layer_done,
            row_idx, grp_idx};
  endfunction

  task automatic run_layer(input int w, input int i, input int a,
                           input int o, input bit inj);
    int t;
    int k;
    dw = w; di = i; da = a; dofm = o;
    push_layer();
    @(negedge clk);
    tb_start = 1;
    @(negedge clk);
    tb_start = 0;
    inject = inj;
    t = n_done;
    k = 0;
    while (n_done == t && k < exp_len + 50) begin
      @(negedge clk);
      k++;
    end
    chk("layer_done seen", n_done - t, 1);
    @(negedge clk);
    inject = 0;
    chk("scoreboard drained", sb.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("idle after layer", busy, 0);
    end
  endtask

  initial begin
    bit found;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset outputs", outs(), 0);
    rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      chk("idle outputs", outs(), 0);
    end

    run_layer(1, 1, 1, 1, 0);
    run_layer(1, 1, 1, 10, 0);
    run_layer(1, 1, 1, 3, 1);

    dw = 1; di = 1; da = 1; dofm = 1;
    push_layer();
    @(negedge clk);
    tb_start = 1;
    @(negedge clk);
    tb_start = 0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (ifm_load && row_idx == 2) found = 1;
    end
    chk("reached row 2", found, 1);
    rst_n = 0;
    #1;
    chk("outputs in reset", outs(), 0);
    sb.delete();
    @(negedge clk);
    chk("outputs after reset", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle after reset", outs(), 0);
    run_layer(1, 1, 1, 1, 0);

    run_layer(3, 3, 3, 3, 0);
`ifdef SCHED_PERF_CNT_EN
    chk("stall_cycles hold", stall_cycles, exp_stall);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
